// File: rtl/mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader_pkg
// Description : Shared constants for the host-command memory loader: command
//               bytes, FSM state encodings and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_loader_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;

    typedef logic [3:0] state_t;

    localparam state_t S_IDLE  = 4'd0;
    localparam state_t S_AHI   = 4'd1;
    localparam state_t S_ALO   = 4'd2;
    localparam state_t S_LEN   = 4'd3;
    localparam state_t S_WDATA = 4'd4;
    localparam state_t S_RREQ  = 4'd5;
    localparam state_t S_RWAIT = 4'd6;
    localparam state_t S_RSEND = 4'd7;
    localparam state_t S_CSUM  = 4'd8;

    // States in which a host byte may be consumed (CSUM is handled separately).
    function automatic logic is_rx_state(input state_t s);
        return (s == S_IDLE) || (s == S_AHI) || (s == S_ALO) ||
               (s == S_LEN)  || (s == S_WDATA);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : mem_loader
// Description : Decodes a host byte stream (CMD, ADDR_HI, ADDR_LO, LEN, data)
//               into writes to, or reads from, a synchronous memory port.
//               Optional trailing checksum byte enabled by MEM_LOADER_CSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] RxData,
    input  logic              RxValid,
    output logic              RxReady,
    output logic [DATA_W-1:0] TxData,
    output logic              TxValid,
    input  logic              TxReady,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddress,
    output logic [DATA_W-1:0] MemDataIn,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic              Busy,
    output logic              Error
);

    localparam logic [ADDR_W-1:0] c_addr_one = ADDR_W'(1);

    state_t            r_state;
    logic              r_rx_en;
    logic              r_is_read;
    logic [7:0]        r_addr_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [8:0]        r_count;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_din;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_tx_data;
    logic              r_tx_valid;
    logic              r_busy;
    logic              r_error;
`ifdef MEM_LOADER_CSUM_EN
    logic [DATA_W-1:0] r_sum;
`endif

    logic w_rx_ready;
    logic w_rx_fire;
    logic w_tx_fire;
    logic w_last;

    // r_rx_en keeps RxReady low for the reset cycle and the one after it.
    always_comb begin
        w_rx_ready = r_rx_en && is_rx_state(r_state);
`ifdef MEM_LOADER_CSUM_EN
        if (r_rx_en && (r_state == S_CSUM) && !r_is_read) begin
            w_rx_ready = 1'b1;
        end
`endif
    end

    assign w_rx_fire = RxValid && w_rx_ready;
    assign w_tx_fire = r_tx_valid && TxReady;
    assign w_last    = (r_count == 9'd1);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_rx_en    <= 1'b0;
            r_is_read  <= 1'b0;
            r_addr_hi  <= '0;
            r_addr     <= '0;
            r_count    <= '0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_mem_we   <= 1'b0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_error    <= 1'b0;
`ifdef MEM_LOADER_CSUM_EN
            r_sum      <= '0;
`endif
        end else begin
            r_rx_en  <= 1'b1;
            r_mem_we <= 1'b0;
            r_error  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_rx_fire) begin
                        if ((RxData == CMD_WRITE) || (RxData == CMD_READ)) begin
                            r_is_read <= (RxData == CMD_READ);
                            r_busy    <= 1'b1;
                            r_state   <= S_AHI;
                        end else begin
                            r_error <= 1'b1;
                        end
                    end
                end

                S_AHI: begin
                    if (w_rx_fire) begin
                        r_addr_hi <= RxData;
                        r_state   <= S_ALO;
                    end
                end

                S_ALO: begin
                    if (w_rx_fire) begin
                        r_addr  <= ADDR_W'({r_addr_hi, RxData});
                        r_state <= S_LEN;
                    end
                end

                S_LEN: begin
                    if (w_rx_fire) begin
                        r_count <= (RxData == '0) ? 9'd256 : {1'b0, RxData};
`ifdef MEM_LOADER_CSUM_EN
                        r_sum   <= '0;
`endif
                        if (r_is_read) begin
                            r_mem_addr <= r_addr;
                            r_state    <= S_RREQ;
                        end else begin
                            r_state <= S_WDATA;
                        end
                    end
                end

                S_WDATA: begin
                    if (w_rx_fire) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= r_addr;
                        r_mem_din  <= RxData;
                        r_addr     <= r_addr + c_addr_one;
                        r_count    <= r_count - 9'd1;
`ifdef MEM_LOADER_CSUM_EN
                        r_sum      <= r_sum + RxData;
                        if (w_last) begin
                            r_state <= S_CSUM;
                        end
`else
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end
`endif
                    end
                end

                S_RREQ: begin
                    r_state <= S_RWAIT;
                end

                S_RWAIT: begin
                    r_tx_data  <= MemDataOut;
                    r_tx_valid <= 1'b1;
`ifdef MEM_LOADER_CSUM_EN
                    r_sum      <= r_sum + MemDataOut;
`endif
                    r_state    <= S_RSEND;
                end

                S_RSEND: begin
                    if (w_tx_fire) begin
                        r_addr  <= r_addr + c_addr_one;
                        r_count <= r_count - 9'd1;
                        if (w_last) begin
`ifdef MEM_LOADER_CSUM_EN
                            // TxValid stays up; the sum goes out as one more byte.
                            r_tx_data <= r_sum;
                            r_state   <= S_CSUM;
`else
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
`endif
                        end else begin
                            r_tx_valid <= 1'b0;
                            r_mem_addr <= r_addr + c_addr_one;
                            r_state    <= S_RREQ;
                        end
                    end
                end

`ifdef MEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (r_is_read) begin
                        if (w_tx_fire) begin
                            r_tx_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_state    <= S_IDLE;
                        end
                    end else if (w_rx_fire) begin
                        r_error <= (RxData != r_sum);
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign RxReady    = w_rx_ready;
    assign TxData     = r_tx_data;
    assign TxValid    = r_tx_valid;
    assign MemWE      = r_mem_we;
    assign MemAddress = r_mem_addr;
    assign MemDataIn  = r_mem_din;
    assign Busy       = r_busy;
    assign Error      = r_error;

endmodule
`default_nettype wire
